sample_voice_reader: RTL and testbench

- Per-instrument sample source on the producer end of the mixer's per-instrument din/din_valid/din_ready stream.
- On a trigger it fetches a one-shot sample from shared sample memory through a req/gnt/rvalid port.
- Fetched samples are prefetched into a small FIFO, so a sample is ready when the mixer polls this instrument once per sample period.
- The latched velocity is presented alongside the stream.

---
 rtl/sample_voice_reader.sv | 135 +++++++++++++
 tb/tb_sample_voice_reader.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_voice_reader.sv
// One-shot sample voice: fetches words from shared sample memory into a
// small prefetch FIFO and streams them to the mixer with the latched velocity.
module sample_voice_reader #(
  parameter int ADDR_WIDTH = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trigger,
  input  logic [6:0]            trig_velocity,
  input  logic [ADDR_WIDTH-1:0] sample_start,
  input  logic [ADDR_WIDTH-1:0] sample_len,
  output logic [6:0]            velocity,
  output logic [15:0]           dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  playing,
  output logic                  underrun,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_gnt,
  input  logic [15:0]           mem_rdata,
  input  logic                  mem_rvalid
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {
    IDLE,
    PLAY
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic [ADDR_WIDTH-1:0] fetch_left;
  logic [ADDR_WIDTH-1:0] out_left;
  logic                  outstanding;
  logic                  discard;

  logic [15:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] fifo_count;

  logic fifo_empty;
  logic fifo_room;
  logic grant;
  logic push;
  logic pop;

  assign fifo_empty = (fifo_count == '0);
  assign fifo_room  = (fifo_count < CW'(FIFO_DEPTH));

  assign playing    = (state == PLAY);
  assign dout_valid = playing && !fifo_empty;
  assign dout       = dout_valid ? fifo_mem[rd_ptr] : 16'h0000;

  // A fetch is only issued when the FIFO can absorb its reply,
  // so a push can never overflow.
  assign mem_req  = playing && (fetch_left != '0) && !outstanding
                    && fifo_room && !trigger;
  assign mem_addr = fetch_addr;

  assign grant = mem_req && mem_gnt;
  assign push  = !trigger && mem_rvalid && outstanding && !discard;
  assign pop   = !trigger && dout_valid && dout_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      velocity    <= '0;
      fetch_addr  <= '0;
      fetch_left  <= '0;
      out_left    <= '0;
      outstanding <= 1'b0;
      discard     <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      underrun    <= 1'b0;
    end else begin
      underrun <= playing && dout_ready && fifo_empty;
      if (trigger) begin
        velocity   <= trig_velocity;
        fetch_addr <= sample_start;
        fetch_left <= sample_len;
        out_left   <= sample_len;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_count <= '0;
        // A reply still in flight belongs to the old sample: keep the
        // slot reserved but throw the data away when it lands.
        if (outstanding && !mem_rvalid) begin
          discard <= 1'b1;
        end else begin
          outstanding <= 1'b0;
          discard     <= 1'b0;
        end
        state <= (sample_len != '0) ? PLAY : IDLE;
      end else begin
        if (grant) begin
          fetch_addr  <= fetch_addr + 1'b1;
          fetch_left  <= fetch_left - 1'b1;
          outstanding <= 1'b1;
        end else if (mem_rvalid && outstanding) begin
          outstanding <= 1'b0;
          discard     <= 1'b0;
        end
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr   <= rd_ptr + 1'b1;
          out_left <= out_left - 1'b1;
          if (out_left == ADDR_WIDTH'(1)) begin
            state <= IDLE;
          end
        end
        unique case ({push, pop})
          2'b10:   fifo_count <= fifo_count + 1'b1;
          2'b01:   fifo_count <= fifo_count - 1'b1;
          default: fifo_count <= fifo_count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sample_voice_reader.sv
// Bench for sample_voice_reader: memory/arbiter emulation, queue-based
// reference model checked every cycle, plus directed literal checks.
module tb_sample_voice_reader;

  localparam int AW    = 24;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          trigger;
  logic [6:0]    trig_velocity;
  logic [AW-1:0] sample_start;
  logic [AW-1:0] sample_len;
  logic [6:0]    velocity;
  logic [15:0]   dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          playing;
  logic          underrun;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_gnt;
  logic [15:0]   mem_rdata;
  logic          mem_rvalid;

  always #5 clk = ~clk;

  sample_voice_reader #(.ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .trigger(trigger),
    .trig_velocity(trig_velocity), .sample_start(sample_start),
    .sample_len(sample_len), .velocity(velocity), .dout(dout),
    .dout_valid(dout_valid), .dout_ready(dout_ready),
    .playing(playing), .underrun(underrun), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid)
  );

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int lat = 1;
  int last_due = 0;
  int gnt_mode = 0;
  int rdy_mode = 0;

  typedef struct {
    int          due;
    logic [15:0] data;
  } rsp_t;
  rsp_t rq[$];

  logic [15:0]   got[$];
  logic [AW-1:0] gaddr[$];

  // reference model state
  bit            m_play = 0;
  logic [6:0]    m_vel = '0;
  logic [AW-1:0] m_fa = '0;
  logic [AW-1:0] m_fl = '0;
  logic [AW-1:0] m_ol = '0;
  int            m_pend = 0;
  bit            m_und = 0;
  logic [15:0]   m_q[$];

  function automatic logic [15:0] memw(logic [AW-1:0] a);
    if (a == 24'h000100) return 16'h1111;
    if (a == 24'h000101) return 16'h2222;
    if (a == 24'h000102) return 16'h3333;
    return a[15:0] ^ {a[23:16], a[7:0]} ^ 16'hA5C3;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cycle, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
    rst     = 1'b0;
    trigger = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 16'($urandom);
    if (rq.size() > 0 && rq[0].due <= cycle) begin
      mem_rvalid = 1'b1;
      mem_rdata  = rq[0].data;
      void'(rq.pop_front());
    end
    case (gnt_mode)
      0:       mem_gnt = 1'b1;
      1:       mem_gnt = 1'($urandom_range(0, 1));
      default: mem_gnt = 1'b0;
    endcase
    case (rdy_mode)
      0:       dout_ready = 1'b0;
      1:       dout_ready = 1'b1;
      default: dout_ready = 1'($urandom_range(0, 1));
    endcase
    #1;
  endtask

  task automatic fire(logic [AW-1:0] s, logic [AW-1:0] l, logic [6:0] v);
    trigger       = 1'b1;
    sample_start  = s;
    sample_len    = l;
    trig_velocity = v;
  endtask

  task automatic wait_grant(string nm);
    bit found;
    found = 0;
    for (int k = 0; k < 30 && !found; k++) begin
      tick();
      found = mem_req && mem_gnt;
    end
    chk(nm, 32'(found), 32'd1);
  endtask

  task automatic chk_got(string nm, logic [AW-1:0] base, int n);
    chk({nm, "_count"}, 32'(got.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < got.size()) chk(nm, 32'(got[i]), 32'(memw(base + AW'(i))));
    end
  endtask

  // per-cycle compare against the model, then advance it one clock
  always @(negedge clk) begin
    bit          ev;
    bit          er;
    bit          push;
    logic [15:0] pd;
    int          d;
    ev = m_play && m_q.size() > 0;
    er = m_play && m_fl != '0 && m_pend == 0 && m_q.size() < DEPTH && !trigger;
    chk("playing", 32'(playing), 32'(m_play));
    chk("dout_valid", 32'(dout_valid), 32'(ev));
    if (ev) chk("dout", 32'(dout), 32'(m_q[0]));
    chk("mem_req", 32'(mem_req), 32'(er));
    if (er) chk("mem_addr", 32'(mem_addr), 32'(m_fa));
    chk("velocity", 32'(velocity), 32'(m_vel));
    chk("underrun", 32'(underrun), 32'(m_und));

    if (mem_req && mem_gnt) begin
      d = cycle + lat;
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      rq.push_back('{d, memw(mem_addr)});
      gaddr.push_back(mem_addr);
    end
    if (dout_valid && dout_ready && !trigger && !rst) got.push_back(dout);

    if (rst) begin
      m_play = 0; m_vel = '0; m_fa = '0; m_fl = '0; m_ol = '0;
      m_pend = 0; m_und = 0; m_q.delete();
    end else begin
      m_und = m_play && dout_ready && m_q.size() == 0;
      if (trigger) begin
        m_vel = trig_velocity;
        m_fa  = sample_start;
        m_fl  = sample_len;
        m_ol  = sample_len;
        m_q.delete();
        m_pend = (m_pend != 0 && !mem_rvalid) ? 2 : 0;
        m_play = (sample_len != '0);
      end else begin
        push = 0;
        pd   = mem_rdata;
        if (mem_rvalid && m_pend != 0) begin
          push   = (m_pend == 1);
          m_pend = 0;
        end
        if (ev && dout_ready) begin
          void'(m_q.pop_front());
          m_ol = m_ol - 1'b1;
          if (m_ol == '0) m_play = 0;
        end
        if (push) m_q.push_back(pd);
        if (er && mem_gnt) begin
          m_fa   = m_fa + 1'b1;
          m_fl   = m_fl - 1'b1;
          m_pend = 1;
        end
      end
    end
  end

  initial begin
    rst = 1'b1; trigger = 1'b0; trig_velocity = '0;
    sample_start = '0; sample_len = '0; dout_ready = 1'b0;
    mem_gnt = 1'b0; mem_rdata = '0; mem_rvalid = 1'b0;
    tick(); rst = 1'b1;
    tick(); rst = 1'b1;
    chk("rst_playing", 32'(playing), 32'd0);
    chk("rst_valid", 32'(dout_valid), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_vel", 32'(velocity), 32'd0);
    chk("rst_und", 32'(underrun), 32'd0);
    tick();

    // 1: basic play, ready high, 1-cycle memory
    gnt_mode = 0; rdy_mode = 1; lat = 1;
    got.delete(); gaddr.delete();
    tick(); fire(24'h100, 24'd3, 7'd64);
    tick();
    tick();
    chk("t1_valid_early", 32'(dout_valid), 32'd0);
    tick();
    chk("t1_valid_lat", 32'(dout_valid), 32'd1);
    chk("t1_first", 32'(dout), 32'h1111);
    repeat (8) tick();
    chk("t1_vel", 32'(velocity), 32'd64);
    chk("t1_n", 32'(got.size()), 32'd3);
    if (got.size() == 3) begin
      chk("t1_d0", 32'(got[0]), 32'h1111);
      chk("t1_d1", 32'(got[1]), 32'h2222);
      chk("t1_d2", 32'(got[2]), 32'h3333);
    end
    chk("t1_na", 32'(gaddr.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < gaddr.size()) chk("t1_addr", 32'(gaddr[i]), 32'h100 + 32'(i));
    end
    chk("t1_idle", 32'(playing), 32'd0);

    // 2: ready low fills the FIFO, then drain with pulses
    rdy_mode = 0;
    got.delete(); gaddr.delete();
    tick(); fire(24'h300, 24'd3, 7'd10);
    repeat (12) tick();
    chk("t2_grants", 32'(gaddr.size()), 32'd3);
    chk("t2_noreq", 32'(mem_req), 32'd0);
    chk("t2_valid", 32'(dout_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick(); dout_ready = 1'b1;
      tick();
    end
    tick();
    chk_got("t2_data", 24'h300, 3);
    chk("t2_idle", 32'(playing), 32'd0);

    // 3: retrigger one cycle after a grant, read latency 3
    rdy_mode = 1; lat = 3;
    tick(); fire(24'h400, 24'd10, 7'd20);
    wait_grant("t3_grant_seen");
    tick();
    got.delete(); gaddr.delete();
    fire(24'h200, 24'd2, 7'd21);
    repeat (25) tick();
    chk("t3_grants", 32'(gaddr.size()), 32'd2);
    if (gaddr.size() > 0) chk("t3_addr0", 32'(gaddr[0]), 32'h200);
    chk_got("t3_data", 24'h200, 2);

    // 4: zero-length trigger
    lat = 1;
    got.delete(); gaddr.delete();
    tick(); fire(24'h800, 24'd0, 7'd5);
    repeat (6) begin
      tick();
      chk("t4_playing", 32'(playing), 32'd0);
      chk("t4_valid", 32'(dout_valid), 32'd0);
    end
    chk("t4_grants", 32'(gaddr.size()), 32'd0);

    // 5: grant stalled with ready high and an empty FIFO
    gnt_mode = 2;
    got.delete(); gaddr.delete();
    tick(); fire(24'h500, 24'd2, 7'd9);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("t5_req", 32'(mem_req), 32'd1);
      chk("t5_addr", 32'(mem_addr), 32'h500);
      if (i >= 2) chk("t5_und", 32'(underrun), 32'd1);
    end
    gnt_mode = 0;
    repeat (10) tick();
    chk_got("t5_data", 24'h500, 2);

    // 6: reset with a request outstanding, stray reply, replay
    lat = 4;
    tick(); fire(24'h600, 24'd8, 7'd33);
    wait_grant("t6_grant_seen");
    tick(); rst = 1'b1;
    tick();
    chk("t6_playing", 32'(playing), 32'd0);
    chk("t6_valid", 32'(dout_valid), 32'd0);
    chk("t6_req", 32'(mem_req), 32'd0);
    chk("t6_vel", 32'(velocity), 32'd0);
    chk("t6_und", 32'(underrun), 32'd0);
    repeat (8) begin
      tick();
      chk("t6_stray", 32'(dout_valid), 32'd0);
    end
    lat = 1;
    got.delete(); gaddr.delete();
    tick(); fire(24'h700, 24'd2, 7'd17);
    repeat (10) tick();
    chk_got("t6_data", 24'h700, 2);

    // random mix incl. address wrap, retriggers and resets
    for (int it = 0; it < 60; it++) begin
      tick();
      gnt_mode = $urandom_range(0, 1);
      rdy_mode = $urandom_range(1, 2);
      lat      = $urandom_range(1, 4);
      if ($urandom_range(0, 15) == 0) begin
        rst = 1'b1;
      end else begin
        fire(($urandom_range(0, 3) == 0) ? 24'hFFFFFE : AW'($urandom),
             AW'($urandom_range(0, 9)), 7'($urandom));
      end
      repeat ($urandom_range(1, 30)) tick();
    end
    rdy_mode = 1; gnt_mode = 0;
    repeat (40) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
